clock_enable_sequencer: RTL and testbench
=========================================

// Module: clock_enable_sequencer
// PURPOSE
//  Brings up gated global clocks (BUFGCE-style buffers) after a PLL/MMCM reset.
//  - Pulses the PLL reset, then waits for LOCKED to stay stable.
//  - Enables the buffer CE of each output domain in turn, staggered to limit di/dt.
//  - Releases the per-domain resets and reports READY.
//  - On lock loss or RESTART: shuts every domain down and re-sequences from the start.
//  Sits beside the platform clock buffers and runs on the free-running input reference clock.
// PARAMETERS
//  NUM_DOMAINS        4    number of gated output clock domains (1..16)
//  PLL_RST_CYCLES     16   cycles PLL_RESET is held high per attempt (>=1)
//  LOCK_STABLE_CYCLES 256  consecutive synchronized-locked cycles required (>=1)
//  STAGGER_CYCLES     8    cycles between successive BUF_CE rises (>=1)
//  DOM_RST_CYCLES     32   cycles domain resets are held after the last CE rise (>=1)
//  CNT_W              16   shared down-counter width; must hold max(param)-1
// PORTS
//  CLK         in   1            free-running reference clock; sole clock
//  RST         in   1            synchronous, active-high reset
//  PLL_LOCKED  in   1            PLL lock, asynchronous; 2-flop synchronized inside
//  RESTART     in   1            1-cycle request to re-sequence from PLL reset
//  PLL_RESET   out  1            reset to PLL/MMCM, active high
//  BUF_CE      out  NUM_DOMAINS  clock-enable per gated clock buffer
//  DOMAIN_RST  out  NUM_DOMAINS  per-domain reset, active high
//  READY       out  1            all domains clocked and out of reset
//  LOSS_COUNT  out  8            lock-loss events, saturates at 255
// BEHAVIOUR
//  Reset (RST=1 at an edge): state=PLL_RST, counter=PLL_RST_CYCLES-1, PLL_RESET=1,
//   BUF_CE=0, DOMAIN_RST=all 1s, READY=0, LOSS_COUNT=0, synchronizer flops=0.
//  All outputs are registered. lk = PLL_LOCKED after 2 sync flops (2-cycle delay).
//  States:
//  - PLL_RST: PLL_RESET=1; count down. At 0: go to WAIT_LOCK, counter=LOCK_STABLE_CYCLES-1.
//  - WAIT_LOCK: PLL_RESET=0. lk=0 reloads the counter. lk=1 at 0: go to ENABLE,
//     idx=0, counter=0. No timeout: waits indefinitely.
//  - ENABLE: counter==0 sets BUF_CE[idx].
//     - If idx<NUM_DOMAINS-1: idx++, counter=STAGGER_CYCLES-1.
//     - Else: go to RELEASE, counter=DOM_RST_CYCLES-1.
//     - Result: CE rises are exactly STAGGER_CYCLES apart, domain 0 first.
//  - RELEASE: count down. At 0: DOMAIN_RST=0 (all bits on the same edge), go to RUN.
//  - RUN: READY=1. Holds until a fault or RESTART.
//  Fault = lk==0 in ENABLE, RELEASE or RUN.
//   Next edge: BUF_CE=0, DOMAIN_RST=all 1s, READY=0, PLL_RESET=1.
//   Go to PLL_RST with counter reloaded; LOSS_COUNT+1 (saturating).
//  RESTART=1 in any state except PLL_RST: same shutdown and transition; LOSS_COUNT unchanged.
//   RESTART in PLL_RST is ignored (no reload).
//  Fault and RESTART in the same cycle: treated as a fault (count increments once).
//  lk dropping in PLL_RST or WAIT_LOCK: not a fault, no count.
//  Invariant: DOMAIN_RST[i]=1 whenever BUF_CE[i]=0. Resets deassert only after all CEs are high.
//  RST mid-sequence: immediate return to reset values, regardless of state.
// TESTING
//  1 Defaults, lk held 1 from reset: PLL_RESET high 16 cycles; BUF_CE bits rise 8 apart (0..3);
//    DOMAIN_RST falls 32 cycles after BUF_CE[3]; READY rises the next cycle.
//  2 Lock glitch: PLL_LOCKED low 1 cycle at WAIT_LOCK count 100 -> stable count restarts;
//    ENABLE entered 256 cycles after the glitch ends.
//  3 PLL_LOCKED drops in RUN -> 3 cycles later (2 sync + 1) BUF_CE=0, DOMAIN_RST=F, READY=0,
//    PLL_RESET=1; LOSS_COUNT=1.
//  4 RESTART pulse during ENABLE with BUF_CE=4'b0011 -> all CE low next cycle; full
//    re-sequence follows; LOSS_COUNT unchanged.
//  5 260 forced losses -> LOSS_COUNT saturates at 255. Same-cycle fault+RESTART
//    increments exactly once.
//  6 RST asserted in RELEASE -> next cycle all outputs at reset values; NUM_DOMAINS=1
//    variant completes with a single CE rise.

Source files
------------

// File: rtl/clock_enable_sequencer.sv
// Brings gated global clock buffers up after a PLL reset: waits for a stable lock,
// staggers the buffer CEs, releases the domain resets, and re-sequences on lock loss or restart.
module clock_enable_sequencer #(
  parameter int NUM_DOMAINS        = 4,
  parameter int PLL_RST_CYCLES     = 16,
  parameter int LOCK_STABLE_CYCLES = 256,
  parameter int STAGGER_CYCLES     = 8,
  parameter int DOM_RST_CYCLES     = 32,
  parameter int CNT_W              = 16
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   PLL_LOCKED,
  input  logic                   RESTART,
  output logic                   PLL_RESET,
  output logic [NUM_DOMAINS-1:0] BUF_CE,
  output logic [NUM_DOMAINS-1:0] DOMAIN_RST,
  output logic                   READY,
  output logic [7:0]             LOSS_COUNT
);

  localparam int IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  localparam logic [CNT_W-1:0] PLL_RST_LOAD = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LOAD    = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAGGER_LOAD = CNT_W'(STAGGER_CYCLES - 1);
  localparam logic [CNT_W-1:0] DOM_RST_LOAD = CNT_W'(DOM_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO     = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [IDX_W-1:0] IDX_ZERO     = IDX_W'(0);
  localparam logic [IDX_W-1:0] IDX_ONE      = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(NUM_DOMAINS - 1);

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_ENABLE    = 3'd2,
    ST_RELEASE   = 3'd3,
    ST_RUN       = 3'd4
  } state_t;

  state_t                 state_r;
  logic [CNT_W-1:0]       cnt_r;
  logic [IDX_W-1:0]       idx_r;
  logic                   meta_r;
  logic                   lk_r;
  logic                   pll_reset_r;
  logic [NUM_DOMAINS-1:0] buf_ce_r;
  logic [NUM_DOMAINS-1:0] domain_rst_r;
  logic                   ready_r;
  logic [7:0]             loss_count_r;
  logic                   fault_s;
  logic                   shutdown_s;

  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? 8'hFF : (value + 8'h01);
  endfunction

  // Lock loss only counts once domains are being clocked; restart is ignored while the PLL is held in reset.
  always_comb begin
    fault_s    = 1'b0;
    shutdown_s = 1'b0;
    case (state_r)
      ST_ENABLE, ST_RELEASE, ST_RUN: fault_s = ~lk_r;
      default:                       fault_s = 1'b0;
    endcase
    shutdown_s = fault_s | (RESTART & (state_r != ST_PLL_RST));
  end

  // Sequencer state, shared down-counter, lock synchronizer and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r      <= ST_PLL_RST;
      cnt_r        <= PLL_RST_LOAD;
      idx_r        <= IDX_ZERO;
      meta_r       <= 1'b0;
      lk_r         <= 1'b0;
      pll_reset_r  <= 1'b1;
      buf_ce_r     <= {NUM_DOMAINS{1'b0}};
      domain_rst_r <= {NUM_DOMAINS{1'b1}};
      ready_r      <= 1'b0;
      loss_count_r <= 8'h00;
    end else begin
      meta_r <= PLL_LOCKED;
      lk_r   <= meta_r;
      if (shutdown_s) begin
        state_r      <= ST_PLL_RST;
        cnt_r        <= PLL_RST_LOAD;
        idx_r        <= IDX_ZERO;
        pll_reset_r  <= 1'b1;
        buf_ce_r     <= {NUM_DOMAINS{1'b0}};
        domain_rst_r <= {NUM_DOMAINS{1'b1}};
        ready_r      <= 1'b0;
        loss_count_r <= fault_s ? sat_inc8(loss_count_r) : loss_count_r;
      end else begin
        case (state_r)
          ST_PLL_RST: begin
            if (cnt_r == CNT_ZERO) begin
              state_r     <= ST_WAIT_LOCK;
              cnt_r       <= LOCK_LOAD;
              pll_reset_r <= 1'b0;
            end else begin
              cnt_r <= cnt_r - CNT_ONE;
            end
          end
          ST_WAIT_LOCK: begin
            // Any unlocked cycle restarts the stability window; there is no timeout.
            if (!lk_r) begin
              cnt_r <= LOCK_LOAD;
            end else if (cnt_r == CNT_ZERO) begin
              state_r <= ST_ENABLE;
              idx_r   <= IDX_ZERO;
              cnt_r   <= CNT_ZERO;
            end else begin
              cnt_r <= cnt_r - CNT_ONE;
            end
          end
          ST_ENABLE: begin
            if (cnt_r == CNT_ZERO) begin
              buf_ce_r[idx_r] <= 1'b1;
              if (idx_r < IDX_LAST) begin
                idx_r <= idx_r + IDX_ONE;
                cnt_r <= STAGGER_LOAD;
              end else begin
                state_r <= ST_RELEASE;
                cnt_r   <= DOM_RST_LOAD;
              end
            end else begin
              cnt_r <= cnt_r - CNT_ONE;
            end
          end
          ST_RELEASE: begin
            if (cnt_r == CNT_ZERO) begin
              domain_rst_r <= {NUM_DOMAINS{1'b0}};
              state_r      <= ST_RUN;
            end else begin
              cnt_r <= cnt_r - CNT_ONE;
            end
          end
          ST_RUN: begin
            ready_r <= 1'b1;
          end
          default: begin
            state_r      <= ST_PLL_RST;
            cnt_r        <= PLL_RST_LOAD;
            idx_r        <= IDX_ZERO;
            pll_reset_r  <= 1'b1;
            buf_ce_r     <= {NUM_DOMAINS{1'b0}};
            domain_rst_r <= {NUM_DOMAINS{1'b1}};
            ready_r      <= 1'b0;
          end
        endcase
      end
    end
  end

  assign PLL_RESET  = pll_reset_r;
  assign BUF_CE     = buf_ce_r;
  assign DOMAIN_RST = domain_rst_r;
  assign READY      = ready_r;
  assign LOSS_COUNT = loss_count_r;

endmodule

// File: tb/tb_clock_enable_sequencer.sv
// Directed bench: default-parameter sequencer plus a fast single-domain instance for
// lock-loss saturation and fault/restart collision.
module tb_clock_enable_sequencer;

  logic       CLK;
  logic       RST, PLL_LOCKED, RESTART;
  logic       PLL_RESET;
  logic [3:0] BUF_CE, DOMAIN_RST;
  logic       READY;
  logic [7:0] LOSS_COUNT;

  logic       rst_b, locked_b, restart_b;
  logic       pll_reset_b;
  logic [0:0] buf_ce_b, domain_rst_b;
  logic       ready_b;
  logic [7:0] loss_count_b;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_loss;

  clock_enable_sequencer dut (
    .CLK(CLK), .RST(RST), .PLL_LOCKED(PLL_LOCKED), .RESTART(RESTART),
    .PLL_RESET(PLL_RESET), .BUF_CE(BUF_CE), .DOMAIN_RST(DOMAIN_RST),
    .READY(READY), .LOSS_COUNT(LOSS_COUNT)
  );

  clock_enable_sequencer #(
    .NUM_DOMAINS(1), .PLL_RST_CYCLES(2), .LOCK_STABLE_CYCLES(2),
    .STAGGER_CYCLES(1), .DOM_RST_CYCLES(2), .CNT_W(4)
  ) dut_b (
    .CLK(CLK), .RST(rst_b), .PLL_LOCKED(locked_b), .RESTART(restart_b),
    .PLL_RESET(pll_reset_b), .BUF_CE(buf_ce_b), .DOMAIN_RST(domain_rst_b),
    .READY(ready_b), .LOSS_COUNT(loss_count_b)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready_b();
    int k = 0;
    while (ready_b !== 1'b1 && k < 40) begin
      steps(1);
      k++;
    end
    chk("ready_b_wait", {31'd0, ready_b}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1; PLL_LOCKED = 1'b1; RESTART = 1'b0;
    rst_b = 1'b1; locked_b = 1'b1; restart_b = 1'b0;
    steps(3);
    // Reset values
    chk("rst_pll_reset", {31'd0, PLL_RESET}, 32'd1);
    chk("rst_buf_ce", {28'd0, BUF_CE}, 32'h0);
    chk("rst_domain_rst", {28'd0, DOMAIN_RST}, 32'hF);
    chk("rst_ready", {31'd0, READY}, 32'd0);
    chk("rst_loss", {24'd0, LOSS_COUNT}, 32'd0);
    RST = 1'b0;

    // Test 1: nominal bring-up, edges counted from the last reset edge
    steps(15);  chk("t1_pll_reset_n15", {31'd0, PLL_RESET}, 32'd1);
    steps(1);   chk("t1_pll_reset_n16", {31'd0, PLL_RESET}, 32'd0);
    steps(256); chk("t1_ce_n272", {28'd0, BUF_CE}, 32'h0);
    steps(1);   chk("t1_ce_n273", {28'd0, BUF_CE}, 32'h1);
    steps(7);   chk("t1_ce_n280", {28'd0, BUF_CE}, 32'h1);
    steps(1);   chk("t1_ce_n281", {28'd0, BUF_CE}, 32'h3);
    steps(8);   chk("t1_ce_n289", {28'd0, BUF_CE}, 32'h7);
    steps(8);   chk("t1_ce_n297", {28'd0, BUF_CE}, 32'hF);
                chk("t1_drst_n297", {28'd0, DOMAIN_RST}, 32'hF);
    steps(31);  chk("t1_drst_n328", {28'd0, DOMAIN_RST}, 32'hF);
    steps(1);   chk("t1_drst_n329", {28'd0, DOMAIN_RST}, 32'h0);
                chk("t1_ready_n329", {31'd0, READY}, 32'd0);
    steps(1);   chk("t1_ready_n330", {31'd0, READY}, 32'd1);
                chk("t1_pll_reset_n330", {31'd0, PLL_RESET}, 32'd0);

    // Test 3: lock loss in RUN takes effect on the third edge
    PLL_LOCKED = 1'b0;
    steps(2);   chk("t3_ready_hold", {31'd0, READY}, 32'd1);
                chk("t3_ce_hold", {28'd0, BUF_CE}, 32'hF);
    steps(1);   chk("t3_ce_off", {28'd0, BUF_CE}, 32'h0);
                chk("t3_drst_on", {28'd0, DOMAIN_RST}, 32'hF);
                chk("t3_ready_off", {31'd0, READY}, 32'd0);
                chk("t3_pll_reset", {31'd0, PLL_RESET}, 32'd1);
                chk("t3_loss", {24'd0, LOSS_COUNT}, 32'd1);

    // Test 2: one-cycle lock glitch in WAIT_LOCK after edge 171 of the new attempt
    PLL_LOCKED = 1'b1;
    steps(171);
    PLL_LOCKED = 1'b0;
    steps(1);
    PLL_LOCKED = 1'b1;
    steps(258); chk("t2_ce_m430", {28'd0, BUF_CE}, 32'h0);
    steps(1);   chk("t2_ce_m431", {28'd0, BUF_CE}, 32'h1);
    steps(8);   chk("t2_ce_m439", {28'd0, BUF_CE}, 32'h3);

    // Test 4: restart during ENABLE, then a restart pulse inside PLL_RST is ignored
    RESTART = 1'b1;
    steps(1);
    RESTART = 1'b0;
    chk("t4_ce_off", {28'd0, BUF_CE}, 32'h0);
    chk("t4_drst_on", {28'd0, DOMAIN_RST}, 32'hF);
    chk("t4_pll_reset", {31'd0, PLL_RESET}, 32'd1);
    chk("t4_loss_kept", {24'd0, LOSS_COUNT}, 32'd1);
    steps(4);
    RESTART = 1'b1;
    steps(1);
    RESTART = 1'b0;
    steps(10);  chk("t4_pll_reset_r15", {31'd0, PLL_RESET}, 32'd1);
    steps(1);   chk("t4_pll_reset_r16", {31'd0, PLL_RESET}, 32'd0);
    steps(257); chk("t4_ce_r273", {28'd0, BUF_CE}, 32'h1);
    steps(24);  chk("t4_ce_r297", {28'd0, BUF_CE}, 32'hF);
    steps(33);  chk("t4_ready_r330", {31'd0, READY}, 32'd1);
                chk("t4_loss_r330", {24'd0, LOSS_COUNT}, 32'd1);

    // Test 6a: RST asserted while in RELEASE
    RESTART = 1'b1;
    steps(1);
    RESTART = 1'b0;
    chk("t6_ready_off", {31'd0, READY}, 32'd0);
    steps(300);
    chk("t6_ce_release", {28'd0, BUF_CE}, 32'hF);
    chk("t6_drst_release", {28'd0, DOMAIN_RST}, 32'hF);
    RST = 1'b1;
    steps(1);
    chk("t6_rst_pll_reset", {31'd0, PLL_RESET}, 32'd1);
    chk("t6_rst_ce", {28'd0, BUF_CE}, 32'h0);
    chk("t6_rst_drst", {28'd0, DOMAIN_RST}, 32'hF);
    chk("t6_rst_ready", {31'd0, READY}, 32'd0);
    chk("t6_rst_loss", {24'd0, LOSS_COUNT}, 32'd0);
    RST = 1'b0;

    // Test 6b: single-domain instance completes with one CE rise
    rst_b = 1'b0;
    steps(4);   chk("b_ce_n4", {31'd0, buf_ce_b}, 32'd0);
    steps(1);   chk("b_ce_n5", {31'd0, buf_ce_b}, 32'd1);
                chk("b_drst_n5", {31'd0, domain_rst_b}, 32'd1);
    steps(2);   chk("b_drst_n7", {31'd0, domain_rst_b}, 32'd0);
                chk("b_ready_n7", {31'd0, ready_b}, 32'd0);
    steps(1);   chk("b_ready_n8", {31'd0, ready_b}, 32'd1);

    // Test 5: 260 forced lock losses saturate the counter at 255
    exp_loss = 8'd0;
    for (int i = 0; i < 260; i++) begin
      wait_ready_b();
      locked_b = 1'b0;
      steps(3);
      locked_b = 1'b1;
      exp_loss = (exp_loss == 8'hFF) ? 8'hFF : exp_loss + 8'd1;
      chk("t5_loss", {24'd0, loss_count_b}, {24'd0, exp_loss});
    end
    chk("t5_loss_sat", {24'd0, loss_count_b}, 32'd255);

    // Test 5b: fault and restart on the same edge count once
    rst_b = 1'b1;
    steps(1);
    rst_b = 1'b0;
    chk("t5b_loss_rst", {24'd0, loss_count_b}, 32'd0);
    wait_ready_b();
    locked_b = 1'b0;
    steps(2);
    restart_b = 1'b1;
    steps(1);
    restart_b = 1'b0;
    locked_b = 1'b1;
    chk("t5b_loss_once", {24'd0, loss_count_b}, 32'd1);
    chk("t5b_ready_off", {31'd0, ready_b}, 32'd0);
    chk("t5b_ce_off", {31'd0, buf_ce_b}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
